// File: rtl/spi_pkg.sv
// Shared definitions for the SPI counter receiver: frame geometry, bit-counter
// sizing, FSM state encoding and the frame acceptance rule.
package spi_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned COUNTER_W  = 14;
  localparam int unsigned RSVD_W     = FRAME_BITS - COUNTER_W;
  localparam int unsigned BITCNT_W   = 5;

  // Bit counter stops here so that any overlong frame still reads as "too long".
  localparam logic [BITCNT_W-1:0] BITCNT_SAT = BITCNT_W'(17);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_e;

  // A frame is good only with exactly FRAME_BITS bits and clear reserved bits.
  function automatic logic frame_ok(input logic [BITCNT_W-1:0] cnt,
                                    input logic [RSVD_W-1:0]   rsvd);
    return (cnt == BITCNT_W'(FRAME_BITS)) && (rsvd == '0);
  endfunction

endpackage

// File: rtl/spi_rx_sync.sv
// N-flop synchronizer for one asynchronous input bit.
// Ports:
//   clk       - destination clock
//   reset     - asynchronous active-high reset
//   rst_val_i - value every stage takes during reset (tie to a constant)
//   d_i       - asynchronous input
//   q_o       - synchronized output
module spi_rx_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rst_val_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff_q <= {STAGES{rst_val_i}};
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/spi_counter_rx.sv
// SPI mode-0 slave that receives 16-bit frames carrying a 14-bit counter value.
// Good frames update o_counter with a one-clk o_data_valid pulse; bad frames
// (wrong length or nonzero reserved bits) give a one-clk o_frame_err pulse.
// Optional build macro SPI_RX_ECHO_EN: miso echoes the previously accepted
// counter value MSB first during the next frame; otherwise miso is tied low.
// Ports:
//   clk          - system clock
//   reset        - asynchronous active-high reset
//   sclk         - SPI clock (async), mode 0
//   mosi         - serial data in, MSB first
//   ss           - active-low slave select framing one transfer
//   miso         - serial data out (echo or constant 0)
//   o_counter    - last accepted counter value
//   o_data_valid - pulse when o_counter updates
//   o_frame_err  - pulse when a frame is rejected
module spi_counter_rx
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sclk,
  input  logic                 mosi,
  input  logic                 ss,
  output logic                 miso,
  output logic [COUNTER_W-1:0] o_counter,
  output logic                 o_data_valid,
  output logic                 o_frame_err
);

  localparam int unsigned        SETTLE_W   = 3;
  localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SYNC_STAGES + 1);

  logic sclk_s;
  logic mosi_s;
  logic ss_s;

  spi_rx_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .reset(reset), .rst_val_i(1'b0), .d_i(sclk), .q_o(sclk_s)
  );

  spi_rx_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .reset(reset), .rst_val_i(1'b0), .d_i(mosi), .q_o(mosi_s)
  );

  spi_rx_sync #(.STAGES(SYNC_STAGES)) u_sync_ss (
    .clk(clk), .reset(reset), .rst_val_i(1'b1), .d_i(ss), .q_o(ss_s)
  );

  // Edge detection, blocked until the synchronizers have flushed their reset
  // values; otherwise ss held low across reset would look like a fresh fall.
  logic                sclk_prev_q;
  logic                ss_prev_q;
  logic [SETTLE_W-1:0] settle_q;
  logic                settled;
  logic                sclk_rise;
  logic                ss_fall;
  logic                ss_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
      settle_q    <= '0;
    end else begin
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
      if (settle_q != SETTLE_MAX) settle_q <= settle_q + SETTLE_W'(1);
    end
  end

  assign settled   = (settle_q == SETTLE_MAX);
  assign sclk_rise = settled &  sclk_s & ~sclk_prev_q;
  assign ss_fall   = settled & ~ss_s   &  ss_prev_q;
  assign ss_rise   = settled &  ss_s   & ~ss_prev_q;

`ifdef SPI_RX_ECHO_EN
  logic                  sclk_fall;
  logic [FRAME_BITS-1:0] tx_load;
  logic [FRAME_BITS-1:0] tx_q;
  logic                  miso_q;

  assign sclk_fall = settled & ~sclk_s & sclk_prev_q;
`endif

  // Receive datapath next-state values
  state_e                state_q;
  logic [FRAME_BITS-1:0] shreg_q;
  logic [FRAME_BITS-1:0] shreg_d;
  logic [BITCNT_W-1:0]   bitcnt_q;
  logic [BITCNT_W-1:0]   bitcnt_d;
  logic [COUNTER_W-1:0]  counter_q;
  logic                  valid_q;
  logic                  err_q;
  logic                  accept;

  assign shreg_d  = {shreg_q[FRAME_BITS-2:0], mosi_s};
  assign bitcnt_d = (bitcnt_q == BITCNT_SAT) ? bitcnt_q : bitcnt_q + BITCNT_W'(1);
  assign accept   = frame_ok(bitcnt_q, shreg_q[FRAME_BITS-1:COUNTER_W]);

`ifdef SPI_RX_ECHO_EN
  assign tx_load = FRAME_BITS'({{RSVD_W{1'b0}}, counter_q});
`endif

  // Frame FSM: collect bits between ss fall and ss rise, then judge the frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      counter_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef SPI_RX_ECHO_EN
      tx_q      <= '0;
      miso_q    <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ss_fall) begin
            state_q  <= SHIFT;
            shreg_q  <= '0;
            bitcnt_q <= '0;
`ifdef SPI_RX_ECHO_EN
            tx_q     <= tx_load;
            miso_q   <= tx_load[FRAME_BITS-1];
`endif
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
          end
`ifdef SPI_RX_ECHO_EN
          if (sclk_fall) begin
            tx_q   <= tx_q << 1;
            miso_q <= tx_q[FRAME_BITS-2];
          end
`endif
          if (ss_rise) state_q <= CHECK;
        end
        CHECK: begin
          if (accept) begin
            counter_q <= shreg_q[COUNTER_W-1:0];
            valid_q   <= 1'b1;
          end else begin
            err_q     <= 1'b1;
          end
          // A new frame may already be starting; take its ss fall here.
          if (ss_fall) begin
            state_q  <= SHIFT;
            shreg_q  <= '0;
            bitcnt_q <= '0;
`ifdef SPI_RX_ECHO_EN
            tx_q     <= tx_load;
            miso_q   <= tx_load[FRAME_BITS-1];
`endif
          end else begin
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_counter    = counter_q;
  assign o_data_valid = valid_q;
  assign o_frame_err  = err_q;

`ifdef SPI_RX_ECHO_EN
  assign miso = miso_q;
`else
  assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_counter_rx.sv
// Directed bench for spi_counter_rx: sclk driven at clk/8, pulses counted on
// the falling clk edge, expected values written out by hand per scenario.
module tb_spi_counter_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        sclk;
  logic        mosi;
  logic        ss;
  logic        miso;
  logic [13:0] o_counter;
  logic        o_data_valid;
  logic        o_frame_err;

  int errors = 0;
  int checks = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  spi_counter_rx #(.SYNC_STAGES(2)) dut (
    .clk(clk),
    .reset(reset),
    .sclk(sclk),
    .mosi(mosi),
    .ss(ss),
    .miso(miso),
    .o_counter(o_counter),
    .o_data_valid(o_data_valid),
    .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_data_valid) valid_cnt++;
    if (o_frame_err) err_cnt++;
    if (o_data_valid && o_frame_err) both_cnt++;
  end

  task automatic half_period();
    repeat (4) @(negedge clk);
  endtask

  task automatic start_frame();
    ss = 1'b0;
    half_period();
  endtask

  // Shift nbits of data MSB first; miso is sampled just before each rising sclk.
  task automatic send_bits(input logic [31:0] data, input int nbits,
                           output logic [31:0] rx);
    rx = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = data[i];
      half_period();
      rx = {rx[30:0], miso};
      sclk = 1'b1;
      half_period();
      sclk = 1'b0;
    end
  endtask

  task automatic end_frame(input int gap);
    half_period();
    ss = 1'b1;
    mosi = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] data, input int nbits,
                            input int gap, output logic [31:0] rx);
    start_frame();
    send_bits(data, nbits, rx);
    end_frame(gap);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    ss = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (o_counter !== 14'h0000) begin
      errors++;
      $display("FAIL reset_counter: got %h expected %h", o_counter, 14'h0000);
    end
    checks++;
    if (o_data_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b expected 0", o_data_valid);
    end
    checks++;
    if (o_frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got %b expected 0", o_frame_err);
    end
    checks++;
    if (miso !== 1'b0) begin
      errors++;
      $display("FAIL reset_miso: got %b expected 0", miso);
    end
    reset = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_valid_frame();
    int v0, e0;
    logic [31:0] rx;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(32'h1234, 16, 12, rx);
    checks++;
    if (o_counter !== 14'h1234) begin
      errors++;
      $display("FAIL valid_counter: got %h expected %h", o_counter, 14'h1234);
    end
    checks++;
    if (valid_cnt - v0 !== 1) begin
      errors++;
      $display("FAIL valid_pulses: got %0d expected 1", valid_cnt - v0);
    end
    checks++;
    if (err_cnt - e0 !== 0) begin
      errors++;
      $display("FAIL valid_no_err: got %0d expected 0", err_cnt - e0);
    end
    checks++;
    if (rx[15:0] !== 16'h0000) begin
      errors++;
      $display("FAIL first_miso: got %h expected %h", rx[15:0], 16'h0000);
    end
  endtask

  task automatic test_reserved_bits();
    int v0, e0;
    logic [31:0] rx;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(32'hC001, 16, 12, rx);
    checks++;
    if (err_cnt - e0 !== 1) begin
      errors++;
      $display("FAIL rsvd_err: got %0d expected 1", err_cnt - e0);
    end
    checks++;
    if (valid_cnt - v0 !== 0) begin
      errors++;
      $display("FAIL rsvd_no_valid: got %0d expected 0", valid_cnt - v0);
    end
    checks++;
    if (o_counter !== 14'h1234) begin
      errors++;
      $display("FAIL rsvd_counter: got %h expected %h", o_counter, 14'h1234);
    end
  endtask

  task automatic test_bad_length();
    int v0, e0;
    logic [31:0] rx;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(32'h0155, 9, 12, rx);
    send_frame(32'h00123, 17, 12, rx);
    checks++;
    if (err_cnt - e0 !== 2) begin
      errors++;
      $display("FAIL len_err: got %0d expected 2", err_cnt - e0);
    end
    checks++;
    if (valid_cnt - v0 !== 0) begin
      errors++;
      $display("FAIL len_no_valid: got %0d expected 0", valid_cnt - v0);
    end
    checks++;
    if (o_counter !== 14'h1234) begin
      errors++;
      $display("FAIL len_counter: got %h expected %h", o_counter, 14'h1234);
    end
  endtask

  task automatic test_back_to_back();
    int v0, e0;
    logic [31:0] rx;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(32'h3FFF, 16, 8, rx);
    checks++;
    if (o_counter !== 14'h3FFF) begin
      errors++;
      $display("FAIL b2b_mid_counter: got %h expected %h", o_counter, 14'h3FFF);
    end
    send_frame(32'h0000, 16, 12, rx);
    checks++;
    if (valid_cnt - v0 !== 2) begin
      errors++;
      $display("FAIL b2b_valid: got %0d expected 2", valid_cnt - v0);
    end
    checks++;
    if (err_cnt - e0 !== 0) begin
      errors++;
      $display("FAIL b2b_no_err: got %0d expected 0", err_cnt - e0);
    end
    checks++;
    if (o_counter !== 14'h0000) begin
      errors++;
      $display("FAIL b2b_counter: got %h expected %h", o_counter, 14'h0000);
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0, e0;
    logic [31:0] rx;
    // Leave a nonzero value so the reset clear is observable.
    send_frame(32'h0777, 16, 12, rx);
    start_frame();
    send_bits(32'h0A, 8, rx);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (o_counter !== 14'h0000) begin
      errors++;
      $display("FAIL midrst_counter: got %h expected %h", o_counter, 14'h0000);
    end
    reset = 1'b0;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_bits(32'hBC, 8, rx);
    end_frame(12);
    checks++;
    if (valid_cnt - v0 !== 0) begin
      errors++;
      $display("FAIL midrst_no_valid: got %0d expected 0", valid_cnt - v0);
    end
    checks++;
    if (err_cnt - e0 !== 0) begin
      errors++;
      $display("FAIL midrst_no_err: got %0d expected 0", err_cnt - e0);
    end
    send_frame(32'h0005, 16, 12, rx);
    checks++;
    if (o_counter !== 14'h0005) begin
      errors++;
      $display("FAIL midrst_after_counter: got %h expected %h", o_counter, 14'h0005);
    end
    checks++;
    if (valid_cnt - v0 !== 1) begin
      errors++;
      $display("FAIL midrst_after_valid: got %0d expected 1", valid_cnt - v0);
    end
  endtask

  task automatic test_echo();
    logic [31:0] rx;
    logic [15:0] exp_echo;
`ifdef SPI_RX_ECHO_EN
    exp_echo = 16'h1234;
`else
    exp_echo = 16'h0000;
`endif
    send_frame(32'h1234, 16, 12, rx);
    send_frame(32'h0001, 16, 12, rx);
    checks++;
    if (rx[15:0] !== exp_echo) begin
      errors++;
      $display("FAIL echo_miso: got %h expected %h", rx[15:0], exp_echo);
    end
    checks++;
    if (o_counter !== 14'h0001) begin
      errors++;
      $display("FAIL echo_counter: got %h expected %h", o_counter, 14'h0001);
    end
    checks++;
    if (both_cnt !== 0) begin
      errors++;
      $display("FAIL both_pulses: got %0d expected 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_reserved_bits();
    test_bad_length();
    test_back_to_back();
    test_reset_mid_frame();
    test_echo();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
